tpu_dispatch_sequencer: RTL and testbench
=========================================

TPU_DISPATCH_SEQUENCER -- requirements
Module: tpu_dispatch_sequencer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of systolic_top instances driven (1..16).
REQ-002 SHALL have parameter CMD_DEPTH, default 8: command FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TAG_WIDTH, default 8: command tag width.
REQ-004 SHALL have parameter CNT_WIDTH, default 8: IRQ coalescing counter and threshold width.
REQ-005 SHALL have parameter TMO_WIDTH, default 16: IRQ timeout counter width.
REQ-006 clk  input  1  sole clock, all logic rising-edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 cmd_valid / cmd_ready  input / output  1 / 1  command push handshake.
REQ-009 cmd_tag / cmd_gelu  input  TAG_WIDTH / 1  command tag; GELU enable for that job.
REQ-010 core_start  output  NUM_CORES  one-cycle start pulse per core.
REQ-011 core_gelu_en  output  NUM_CORES  per-core GELU enable, held for the job.
REQ-012 core_done  input  NUM_CORES  per-core done pulse from systolic_top.
REQ-013 cpl_valid / cpl_ready  output / input  1 / 1  completion handshake.
REQ-014 cpl_tag / cpl_core  output  TAG_WIDTH / $clog2(NUM_CORES) (min 1)  completed tag and core index.
REQ-015 irq_threshold  input  CNT_WIDTH  completions per interrupt; 0 treated as 1.
REQ-016 irq_timeout  input  TMO_WIDTH  cycles before a partial batch interrupts; 0 disables.
REQ-017 irq_ack  input  1  clears interrupt and pending count.
REQ-018 irq  output  1  coalesced completion interrupt, level.
REQ-019 cmd_count  output  $clog2(CMD_DEPTH)+1  FIFO occupancy.
REQ-020 all_idle  output  1  FIFO empty and every core FREE.

Function
REQ-021 FIFO: push on cmd_valid&&cmd_ready; cmd_ready = (cmd_count<CMD_DEPTH); pointers wrap modulo CMD_DEPTH; no write-through bypass.
REQ-022 Per-core state FREE/RUN/CPL; FREE->RUN on dispatch, RUN->CPL on core_done, CPL->FREE on completion handshake for that core.
REQ-023 At most one dispatch per cycle: if FIFO non-empty and any core FREE, pick first FREE core at or after round-robin pointer; pop head, pulse core_start for that core, latch tag, drive core_gelu_en from cmd_gelu.
REQ-024 Round-robin pointer advances to dispatched index+1 (wrapping at NUM_CORES).
REQ-025 Latency: command pushed at cycle N into empty FIFO with FREE core -> core_start at cycle N+1.
REQ-026 Push and pop in same cycle: cmd_count unchanged.
REQ-027 core_done on a core not in RUN SHALL be ignored.
REQ-028 Completion arbiter: lowest-index CPL core at or after its own round-robin pointer drives cpl_valid/cpl_tag/cpl_core; outputs stable while cpl_valid&&!cpl_ready.
REQ-029 Core leaving CPL on handshake at cycle N may be dispatched at N+1 at earliest.
REQ-030 core_gelu_en holds until the core's next dispatch.
REQ-031 Pending count increments on each completion handshake, saturating at 2^CNT_WIDTH-1.
REQ-032 irq sets when pending >= max(irq_threshold,1), or when timeout enabled, pending>0 and timer reaches irq_timeout; remains set until irq_ack.
REQ-033 Timer counts cycles while pending>0 and irq low; clears when pending=0 or irq set.
REQ-034 irq_ack clears irq, pending and timer; simultaneous handshake leaves pending=1.
REQ-035 all_idle = (cmd_count==0) and all cores FREE.

Reset
REQ-036 While rst_n low at a clock edge: FIFO emptied, cores FREE, both RR pointers 0, pending/timer 0; core_start, core_gelu_en, cpl_valid, irq, cmd_ready, cmd_count SHALL be 0; all_idle 0.
REQ-037 First cycle after release: cmd_ready=1, all_idle=1; reset mid-job discards queued commands and in-flight tags; core_done during reset ignored.

Verification
REQ-038 Push tags 0x11,0x22,0x33 (NUM_CORES=4, idle) -> core_start on cores 0,1,2 on successive cycles, cmd_count back to 0.
REQ-039 Push 12 commands with cores never done, CMD_DEPTH=8 -> 4 dispatched, cmd_count=8, cmd_ready=0; pulse core_done[2], handshake -> next tag starts on core 2.
REQ-040 core_done on cores 1 and 3 same cycle, cpl_ready held low 3 cycles -> cpl_valid stable with core 1, then core 3 after.
REQ-041 irq_threshold=3, timeout=0: 2 completions -> irq=0; third -> irq=1 next cycle; irq_ack -> irq=0, pending=0.
REQ-042 irq_threshold=10, irq_timeout=5, single completion -> irq=1 after 5 cycles; ack with simultaneous completion -> pending=1.
REQ-043 rst_n low 1 cycle with 3 queued and 2 running -> cmd_count=0, all_idle=1, no core_start; late core_done ignored.

Source files
------------

// File: rtl/tpu_dispatch_sequencer.sv
// tpu_dispatch_sequencer
//   Queues tagged jobs and hands each to the next FREE systolic core
//   (round-robin). It collects finished jobs back through a single
//   completion port, also round-robin, and coalesces completions into a
//   level interrupt. The interrupt fires on a count threshold or on a
//   timeout.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   cmd_valid/ready, cmd_tag,  command push; cmd_gelu selects GELU for the job
//   cmd_gelu
//   core_start[NUM_CORES]      one-cycle start pulse per core
//   core_gelu_en[NUM_CORES]    GELU enable, held until the core's next dispatch
//   core_done[NUM_CORES]       done pulse from each core (ignored unless RUN)
//   cpl_valid/ready, cpl_tag,  completion handshake (tag and core index)
//   cpl_core
//   irq_threshold, irq_timeout coalescing controls (0 => 1 / 0 => no timeout)
//   irq_ack, irq               interrupt clear / level interrupt
//   cmd_count, all_idle        FIFO occupancy; FIFO empty and all cores FREE

// Per-core job slot: tracks FREE/RUN/CPL and holds the tag and GELU enable
// of the job the core was last given.
module tpu_core_slot #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 done,
  input  logic                 ack_cpl,
  input  logic [TAG_WIDTH-1:0] tag_in,
  input  logic                 gelu_in,
  output logic                 is_free,
  output logic                 is_cpl,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 gelu_en
);
  typedef enum logic [1:0] {S_FREE = 2'd0, S_RUN = 2'd1, S_CPL = 2'd2} slot_state_e;

  slot_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FREE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FREE:  if (start)   state_nxt = S_RUN;
      S_RUN:   if (done)    state_nxt = S_CPL;
      S_CPL:   if (ack_cpl) state_nxt = S_FREE;
      default:              state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag     <= '0;
      gelu_en <= 1'b0;
    end else if (start) begin
      tag     <= tag_in;
      gelu_en <= gelu_in;
    end
  end

  assign is_free = (state == S_FREE);
  assign is_cpl  = (state == S_CPL);
endmodule

module tpu_dispatch_sequencer #(
  parameter  int NUM_CORES = 4,
  parameter  int CMD_DEPTH = 8,
  parameter  int TAG_WIDTH = 8,
  parameter  int CNT_WIDTH = 8,
  parameter  int TMO_WIDTH = 16,
  localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int PTR_W     = $clog2(CMD_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [TAG_WIDTH-1:0] cmd_tag,
  input  logic                 cmd_gelu,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NUM_CORES-1:0] core_gelu_en,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 cpl_valid,
  input  logic                 cpl_ready,
  output logic [TAG_WIDTH-1:0] cpl_tag,
  output logic [CORE_W-1:0]    cpl_core,
  input  logic [CNT_WIDTH-1:0] irq_threshold,
  input  logic [TMO_WIDTH-1:0] irq_timeout,
  input  logic                 irq_ack,
  output logic                 irq,
  output logic [PTR_W:0]       cmd_count,
  output logic                 all_idle
);
  // base+k modulo NUM_CORES, for k in [0, NUM_CORES]
  function automatic logic [CORE_W-1:0] rot(input logic [CORE_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return CORE_W'(s);
  endfunction

  // ---------------- command FIFO ----------------
  logic [TAG_WIDTH:0] mem [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic [TAG_WIDTH:0] head;
  logic               push, disp_go;

  // count never exceeds CMD_DEPTH (a power of two), so its MSB means full
  assign cmd_ready = rst_n && !count[PTR_W];
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign cmd_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_gelu, cmd_tag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (disp_go) rd_ptr <= rd_ptr + 1'b1;
      case ({push, disp_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- per-core slots ----------------
  logic [NUM_CORES-1:0]                core_free, core_cpl;
  logic [NUM_CORES-1:0][TAG_WIDTH-1:0] slot_tag;
  logic [CORE_W-1:0]                   cpl_sel;
  logic                                cpl_hs;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    tpu_core_slot #(.TAG_WIDTH(TAG_WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (core_start[g]),
      .done    (core_done[g]),
      .ack_cpl (cpl_hs && (cpl_sel == CORE_W'(g))),
      .tag_in  (head[TAG_WIDTH-1:0]),
      .gelu_in (head[TAG_WIDTH]),
      .is_free (core_free[g]),
      .is_cpl  (core_cpl[g]),
      .tag     (slot_tag[g]),
      .gelu_en (core_gelu_en[g])
    );
  end

  // ---------------- dispatch arbiter ----------------
  logic [CORE_W-1:0] rr_q, disp_idx;
  logic              disp_found;

  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!disp_found && core_free[rot(rr_q, k)]) begin
        disp_found = 1'b1;
        disp_idx   = rot(rr_q, k);
      end
    end
  end

  // Only stored entries dispatch; a command pushed this cycle waits a cycle.
  assign disp_go    = rst_n && (count != '0) && disp_found;
  assign core_start = disp_go ? (NUM_CORES'(1) << disp_idx) : '0;

  // ---------------- completion arbiter ----------------
  logic [CORE_W-1:0] crr_q, cpl_raw_idx, lock_idx_q;
  logic              cpl_raw_found, lock_q;

  always_comb begin
    cpl_raw_found = 1'b0;
    cpl_raw_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!cpl_raw_found && core_cpl[rot(crr_q, k)]) begin
        cpl_raw_found = 1'b1;
        cpl_raw_idx   = rot(crr_q, k);
      end
    end
  end

  // A stalled offer stays on the same core even if a higher-priority core
  // finishes meanwhile; the locked core cannot leave CPL without a handshake.
  assign cpl_sel   = lock_q ? lock_idx_q : cpl_raw_idx;
  assign cpl_valid = rst_n && (lock_q || cpl_raw_found);
  assign cpl_hs    = cpl_valid && cpl_ready;
  assign cpl_tag   = slot_tag[cpl_sel];
  assign cpl_core  = cpl_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q       <= '0;
      crr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (disp_go) rr_q  <= rot(disp_idx, 1);
      if (cpl_hs)  crr_q <= rot(cpl_sel, 1);
      lock_q     <= cpl_valid && !cpl_ready;
      lock_idx_q <= cpl_sel;
    end
  end

  // ---------------- interrupt coalescing ----------------
  logic [CNT_WIDTH-1:0] pending, pending_nxt, thr_eff;
  logic [TMO_WIDTH-1:0] timer, timer_nxt;
  logic [TMO_WIDTH:0]   timer_inc;
  logic                 count_on, tmo_hit, irq_nxt;

  assign thr_eff     = (irq_threshold == '0) ? CNT_WIDTH'(1) : irq_threshold;
  assign pending_nxt = irq_ack ? CNT_WIDTH'(cpl_hs)
                     : (cpl_hs && (pending != '1)) ? pending + 1'b1 : pending;
  // timer only runs for a non-empty, not-yet-signalled batch with timeout on
  assign count_on    = !irq_ack && (pending != '0) && !irq && (irq_timeout != '0);
  assign timer_inc   = {1'b0, timer} + 1'b1;
  assign timer_nxt   = count_on ? timer_inc[TMO_WIDTH-1:0] : '0;
  assign tmo_hit     = count_on && (timer_inc >= {1'b0, irq_timeout});
  // threshold compares the post-update count so irq rises the cycle after
  // the completion that crosses it
  assign irq_nxt     = (irq && !irq_ack) || (pending_nxt >= thr_eff) || tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      timer   <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      timer   <= timer_nxt;
      irq     <= irq_nxt;
    end
  end

  assign all_idle = rst_n && (count == '0) && (&core_free);
endmodule

// File: tb/tb_tpu_dispatch_sequencer.sv
// Self-checking bench for tpu_dispatch_sequencer: directed scenarios followed
// by randomized traffic, all compared against a queue/array reference model.
module tb_tpu_dispatch_sequencer;
  localparam int NC = 4, DEPTH = 8, TW = 8, CNTW = 8, TMW = 16, CIW = 2;
  localparam int FR = 0, RN = 1, CP = 2;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            cmd_valid, cmd_ready, cmd_gelu;
  logic [TW-1:0]   cmd_tag, cpl_tag;
  logic [NC-1:0]   core_start, core_gelu_en, core_done;
  logic            cpl_valid, cpl_ready, irq_ack, irq, all_idle;
  logic [CIW-1:0]  cpl_core;
  logic [CNTW-1:0] irq_threshold;
  logic [TMW-1:0]  irq_timeout;
  logic [3:0]      cmd_count;

  always #5 clk = ~clk;

  tpu_dispatch_sequencer #(.NUM_CORES(NC), .CMD_DEPTH(DEPTH), .TAG_WIDTH(TW),
                           .CNT_WIDTH(CNTW), .TMO_WIDTH(TMW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tag(cmd_tag), .cmd_gelu(cmd_gelu), .core_start(core_start),
    .core_gelu_en(core_gelu_en), .core_done(core_done), .cpl_valid(cpl_valid),
    .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_core(cpl_core),
    .irq_threshold(irq_threshold), .irq_timeout(irq_timeout), .irq_ack(irq_ack),
    .irq(irq), .cmd_count(cmd_count), .all_idle(all_idle)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [TW:0]   mq[$];
  int            st[NC];
  logic [TW-1:0] mtag[NC];
  logic [NC-1:0] mgelu;
  int            rr, crr, held_idx, pend, tmr, e_d, e_c;
  bit            held, mirq;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NC; i++) begin st[i] = FR; mtag[i] = '0; end
    mgelu = '0; rr = 0; crr = 0; held = 0; held_idx = 0;
    pend = 0; tmr = 0; mirq = 0;
  endtask

  task automatic pick();
    e_d = -1; e_c = -1;
    if (rst_n) begin
      if (mq.size() > 0)
        for (int k = 0; k < NC; k++)
          if (e_d < 0 && st[(rr + k) % NC] == FR) e_d = (rr + k) % NC;
      if (held) e_c = held_idx;
      else
        for (int k = 0; k < NC; k++)
          if (e_c < 0 && st[(crr + k) % NC] == CP) e_c = (crr + k) % NC;
    end
  endtask

  function automatic bit idle_m();
    bit r;
    r = rst_n && (mq.size() == 0);
    for (int i = 0; i < NC; i++) if (st[i] != FR) r = 0;
    return r;
  endfunction

  task automatic step();
    bit          hs, rdy_m, old_irq;
    int          old_p, thr_eff;
    logic [TW:0] ent;
    if (!rst_n) begin model_reset(); return; end
    rdy_m = mq.size() < DEPTH;
    hs    = (e_c >= 0) && cpl_ready;
    for (int i = 0; i < NC; i++) if (core_done[i] && st[i] == RN) st[i] = CP;
    if (e_d >= 0) begin
      ent = mq.pop_front();
      st[e_d] = RN; mtag[e_d] = ent[TW-1:0]; mgelu[e_d] = ent[TW];
      rr = (e_d + 1) % NC;
    end
    if (hs) begin st[e_c] = FR; crr = (e_c + 1) % NC; held = 0; end
    else begin held = (e_c >= 0); held_idx = e_c; end
    if (cmd_valid && rdy_m) mq.push_back({cmd_gelu, cmd_tag});
    // interrupt: batch size threshold or age of a partial batch
    thr_eff = (irq_threshold == 0) ? 1 : int'(irq_threshold);
    old_p = pend; old_irq = mirq;
    if (irq_ack) begin
      pend = hs ? 1 : 0; tmr = 0; mirq = 0;
    end else begin
      if (hs && pend < (1 << CNTW) - 1) pend++;
      if (old_p > 0 && !old_irq && irq_timeout != 0) begin
        tmr++;
        if (tmr >= int'(irq_timeout)) mirq = 1;
      end else tmr = 0;
    end
    if (pend >= thr_eff) mirq = 1;
  endtask

  // one clock: drive inputs at the falling edge, compare, advance the model
  task automatic tick(input logic v, input logic [TW-1:0] tg, input logic g,
                      input logic [NC-1:0] dn, input logic rdy, input logic ack);
    cmd_valid = v; cmd_tag = tg; cmd_gelu = g; core_done = dn;
    cpl_ready = rdy; irq_ack = ack;
    #1;
    pick();
    chk("core_start", core_start, (e_d >= 0) ? (1 << e_d) : 0);
    chk("cmd_ready", cmd_ready, rst_n && (mq.size() < DEPTH));
    chk("cmd_count", cmd_count, mq.size());
    chk("all_idle", all_idle, idle_m());
    chk("core_gelu_en", core_gelu_en, mgelu);
    chk("irq", irq, mirq);
    chk("cpl_valid", cpl_valid, e_c >= 0);
    if (e_c >= 0) begin
      chk("cpl_core", cpl_core, e_c);
      chk("cpl_tag", cpl_tag, mtag[e_c]);
    end
    step();
    @(negedge clk);
  endtask

  task automatic idle(); tick(0, '0, 0, '0, 0, 0); endtask
  task automatic push(input logic [TW-1:0] t, input logic g); tick(1, t, g, '0, 0, 0); endtask
  task automatic do_reset(); rst_n = 0; idle(); rst_n = 1; endtask
  task automatic complete(input int c);
    tick(0, '0, 0, NC'(1) << c, 0, 0);
    tick(0, '0, 0, '0, 1, 0);
  endtask

  initial begin
    cmd_valid = 0; cmd_tag = '0; cmd_gelu = 0; core_done = '0;
    cpl_ready = 0; irq_ack = 0; irq_threshold = 1; irq_timeout = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    model_reset();

    // reset values, then first cycle after release
    idle();
    rst_n = 1;
    idle();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_idle", all_idle, 1);

    // three pushes land on cores 0,1,2 on successive cycles
    do_reset();
    push(8'h11, 0); chk("r038_start0", core_start, 4'b0001);
    push(8'h22, 1); chk("r038_start1", core_start, 4'b0010);
    push(8'h33, 0); chk("r038_start2", core_start, 4'b0100);
    idle();         chk("r038_count", cmd_count, 0);
    chk("r038_gelu", core_gelu_en, 4'b0010);

    // fill FIFO behind busy cores, then free core 2
    do_reset();
    for (int i = 0; i < 12; i++) push(TW'(8'h40 + i), 0);
    chk("r039_count", cmd_count, 8);
    chk("r039_ready", cmd_ready, 0);
    tick(0, '0, 0, 4'b0100, 0, 0);
    chk("r039_cpl_core", cpl_core, 2);
    chk("r039_cpl_tag", cpl_tag, 8'h42);
    tick(0, '0, 0, '0, 1, 0);
    chk("r039_restart", core_start, 4'b0100);
    idle();
    chk("r039_count2", cmd_count, 7);

    // stalled completion stays on core 1, even when core 0 finishes meanwhile
    do_reset();
    for (int i = 0; i < 4; i++) push(TW'(8'ha0 + i), 0);
    idle();
    tick(0, '0, 0, 4'b1010, 0, 0);
    chk("r040_hold0", cpl_core, 1);
    tick(0, '0, 0, 4'b0001, 0, 0); chk("r040_hold1", cpl_core, 1);
    idle();                        chk("r040_hold2", cpl_core, 1);
    idle();                        chk("r040_hold3", cpl_core, 1);
    tick(0, '0, 0, '0, 1, 0);
    chk("r040_next", cpl_core, 3);
    chk("r040_next_tag", cpl_tag, 8'ha3);
    tick(0, '0, 0, '0, 1, 0);
    chk("r040_last", cpl_core, 0);
    tick(0, '0, 0, '0, 1, 0);
    chk("r040_empty", cpl_valid, 0);

    // threshold coalescing
    irq_threshold = 3; irq_timeout = 0;
    do_reset();
    for (int i = 0; i < 3; i++) push(TW'(8'hc0 + i), 0);
    idle();
    complete(0); chk("r041_irq1", irq, 0);
    complete(1); chk("r041_irq2", irq, 0);
    complete(2); chk("r041_irq3", irq, 1);
    tick(0, '0, 0, '0, 0, 1); chk("r041_ack", irq, 0);
    push(8'hc3, 0); idle();
    complete(3); chk("r041_after_ack", irq, 0);

    // timeout coalescing; ack with a simultaneous completion keeps one pending
    irq_threshold = 10; irq_timeout = 5;
    do_reset();
    push(8'hd0, 0); idle();
    complete(0);
    chk("r042_t0", irq, 0);
    for (int i = 0; i < 4; i++) begin idle(); chk("r042_wait", irq, 0); end
    idle(); chk("r042_fire", irq, 1);
    push(8'hd1, 0); idle();
    tick(0, '0, 0, 4'b0010, 0, 0);
    tick(0, '0, 0, '0, 1, 1);
    chk("r042_ack", irq, 0);
    for (int i = 0; i < 4; i++) begin idle(); chk("r042_wait2", irq, 0); end
    idle(); chk("r042_fire2", irq, 1);

    // reset mid-job
    irq_threshold = 1; irq_timeout = 0;
    do_reset();
    for (int i = 0; i < 7; i++) push(TW'(8'h70 + i), 0);
    tick(0, '0, 0, 4'b0011, 0, 0);
    chk("r043_count_pre", cmd_count, 3);
    rst_n = 0;
    tick(0, '0, 0, 4'b0100, 0, 0);
    rst_n = 1;
    #1;
    chk("r043_count", cmd_count, 0);
    chk("r043_idle", all_idle, 1);
    chk("r043_start", core_start, 0);
    chk("r043_ready", cmd_ready, 1);
    tick(0, '0, 0, 4'b1000, 0, 0);
    chk("r043_late_done", cpl_valid, 0);
    chk("r043_idle2", all_idle, 1);

    // randomized traffic
    irq_threshold = CNTW'($urandom_range(0, 4));
    irq_timeout   = TMW'($urandom_range(0, 12));
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        irq_threshold = CNTW'($urandom_range(0, 4));
        irq_timeout   = TMW'($urandom_range(0, 12));
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick(1'($urandom_range(0, 1)), TW'($urandom), 1'($urandom),
           NC'($urandom) & NC'($urandom), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0));
    end
    rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
